fetch_pc_unit: RTL and testbench

Instruction-fetch stage of the RV32 pipeline, directly upstream of the branch predictor and its consumer.
- Owns the PC register.
- Drives the predictor read address and takes its hit/target to choose the next PC.
- Issues instruction-cache requests and honours the cache's stall handshake.
- Applies mispredict redirects from EX.
- Loads the IF/ID pipeline register consumed by decode.

---
 rtl/fetch_pc_unit_pkg.sv | 17 +
 rtl/fetch_pc_unit_ifid.sv | 69 ++++++
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 tb/tb_fetch_pc_unit.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// State encodings, reset constants and PC helpers.
package fetch_pc_unit_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] BOOT_PC_DEF = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_ifid.sv
// IF/ID pipeline register: load, hold or flush to a NOP bubble.
// Flush wins over load; only valid and inst are touched by a flush.
module fetch_pc_unit_ifid
    import fetch_pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;

    // Next-entry selection: flush bubble, new load, or hold.
    always_comb begin
        valid_d  = valid_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        taken_d  = taken_q;
        target_d = target_q;
        if (flush_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end else if (load_i) begin
            valid_d  = 1'b1;
            inst_d   = inst_i;
            pc_d     = pc_i;
            taken_d  = pred_taken_i;
            target_d = pred_target_i;
        end
    end

    // Entry storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            inst_q   <= NOP_INST;
            pc_q     <= 32'h0;
            taken_q  <= 1'b0;
            target_q <= 32'h0;
        end else begin
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign valid_o       = valid_q;
    assign inst_o        = inst_q;
    assign pc_o          = pc_q;
    assign pred_taken_o  = taken_q;
    assign pred_target_o = target_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC selection and icache handshake.
// A redirect during a cache miss is parked until the access ends.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_PC = BOOT_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectPC_i,
    output logic [31:0] BpAddr_o,
    input  logic        BpHit_i,
    input  logic [31:0] BpTarget_i,
    output logic        ICacheReq_o,
    output logic [31:0] ICacheAddr_o,
    input  logic        ICacheStall_i,
    input  logic [31:0] ICacheRdata_i,
    output logic        Valid_o,
    output logic [31:0] Inst_o,
    output logic [31:0] InstPC_o,
    output logic        PredTaken_o,
    output logic [31:0] PredTarget_o
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] seq_pc;
    logic [31:0] pred_pc;
    logic        load;
    logic        flush;

    // Next state, next PC and IF/ID control for the current cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        load    = 1'b0;
        flush   = 1'b0;
        seq_pc  = pc_q + 32'd4;
        pred_pc = BpHit_i ? align_pc(BpTarget_i) : seq_pc;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH, S_WAIT: begin
                if (ICacheStall_i) begin
                    if (Redirect_i) begin
                        redir_d = align_pc(RedirectPC_i);
                        flush   = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_FETCH;
                    if (Redirect_i) begin
                        pc_d  = align_pc(RedirectPC_i);
                        flush = 1'b1;
                    end else if (!Stall_i) begin
                        pc_d = pred_pc;
                        load = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (Redirect_i) begin
                    redir_d = align_pc(RedirectPC_i);
                end
                if (!ICacheStall_i) begin
                    pc_d    = redir_d;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PC, state and parked redirect target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_PC;
            redir_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
        end
    end

    assign BpAddr_o     = pc_q;
    assign ICacheAddr_o = pc_q;
    assign ICacheReq_o  = (state_q != S_IDLE);

    fetch_pc_unit_ifid u_ifid (
        .clk           (clk),
        .rst_n         (rst),
        .load_i        (load),
        .flush_i       (flush),
        .inst_i        (ICacheRdata_i),
        .pc_i          (pc_q),
        .pred_taken_i  (BpHit_i),
        .pred_target_i (pred_pc),
        .valid_o       (Valid_o),
        .inst_o        (Inst_o),
        .pc_o          (InstPC_o),
        .pred_taken_o  (PredTaken_o),
        .pred_target_o (PredTarget_o)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic.
// Expected values come from a transaction-level fetch model.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] bp_addr;
    logic        bp_hit;
    logic [31:0] bp_tgt;
    logic        c_req;
    logic [31:0] c_addr;
    logic        c_stall;
    logic [31:0] c_data;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        p_taken;
    logic [31:0] p_target;

    int checks = 0;
    int errors = 0;

    // Model: fetch has started, optional parked redirect, PC, IF/ID entry.
    bit          m_started;
    bit          m_pend_v;
    logic [31:0] m_pend;
    logic [31:0] m_pc;
    bit          m_v;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    bit          m_pt;
    logic [31:0] m_ptg;

    fetch_pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .Stall_i       (stall),
        .Redirect_i    (redir),
        .RedirectPC_i  (redir_pc),
        .BpAddr_o      (bp_addr),
        .BpHit_i       (bp_hit),
        .BpTarget_i    (bp_tgt),
        .ICacheReq_o   (c_req),
        .ICacheAddr_o  (c_addr),
        .ICacheStall_i (c_stall),
        .ICacheRdata_i (c_data),
        .Valid_o       (valid),
        .Inst_o        (inst),
        .InstPC_o      (inst_pc),
        .PredTaken_o   (p_taken),
        .PredTarget_o  (p_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [162:0] dut_vec();
        return {c_req, c_addr, bp_addr, valid, inst,
                inst_pc, p_taken, p_target};
    endfunction

    function automatic logic [162:0] mdl_vec();
        return {m_started, m_pc, m_pc, m_v, m_inst,
                m_ipc, m_pt, m_ptg};
    endfunction

    task automatic mdl_reset();
        m_started = 0;
        m_pend_v  = 0;
        m_pend    = 0;
        m_pc      = 0;
        m_v       = 0;
        m_inst    = NOP;
        m_ipc     = 0;
        m_pt      = 0;
        m_ptg     = 0;
    endtask

    // One clock of the fetch rules applied to the current inputs.
    task automatic mdl_update();
        logic [31:0] nxt;
        if (!m_started) begin
            m_started = 1;
        end else if (m_pend_v) begin
            if (redir) m_pend = redir_pc & ~32'd3;
            if (!c_stall) begin
                m_pc     = m_pend;
                m_pend_v = 0;
            end
        end else if (c_stall) begin
            if (redir) begin
                m_pend_v = 1;
                m_pend   = redir_pc & ~32'd3;
                m_v      = 0;
                m_inst   = NOP;
            end
        end else if (redir) begin
            m_pc   = redir_pc & ~32'd3;
            m_v    = 0;
            m_inst = NOP;
        end else if (!stall) begin
            nxt    = bp_hit ? (bp_tgt & ~32'd3) : m_pc + 32'd4;
            m_v    = 1;
            m_inst = c_data;
            m_ipc  = m_pc;
            m_pt   = bp_hit;
            m_ptg  = nxt;
            m_pc   = nxt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) mdl_update();
        else mdl_reset();
        #1;
    endtask

    task automatic quiet();
        stall    = 0;
        redir    = 0;
        redir_pc = 0;
        bp_hit   = 0;
        bp_tgt   = 0;
        c_stall  = 0;
        c_data   = $urandom;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        quiet();
        redir    = 1;
        redir_pc = a;
        step();
        quiet();
    endtask

    task automatic do_reset();
        quiet();
        rst = 0;
        step();
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        quiet();
        rst = 0;
        #3;
        mdl_reset();
        step();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reset_vec got %h exp %h", dut_vec(), mdl_vec());
        end
        checks++;
        if ({c_req, valid, inst} !== {1'b0, 1'b0, NOP}) begin
            errors++;
            $display("FAIL reset_const req=%b v=%b inst=%h",
                     c_req, valid, inst);
        end
    endtask

    task automatic test_reset_release();
        do_reset();
        checks++;
        if (c_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req got %b exp 0", c_req);
        end
        step();
        checks++;
        if ({c_req, c_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_req got %b/%h exp 1/0", c_req, c_addr);
        end
        for (int k = 0; k < 4; k++) begin
            c_data = $urandom;
            step();
            checks++;
            if ({valid, inst_pc} !== {1'b1, 32'(4 * k)} ||
                dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL seq_pc k=%0d got %b/%h exp 1/%h",
                         k, valid, inst_pc, 4 * k);
            end
        end
    endtask

    task automatic test_idle_redirect();
        do_reset();
        redir    = 1;
        redir_pc = 32'h80;
        step();
        quiet();
        checks++;
        if (c_addr !== 32'h0 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL idle_redir addr got %h exp 0", c_addr);
        end
    endtask

    task automatic test_pred_taken();
        goto_pc(32'h10);
        bp_hit = 1;
        bp_tgt = 32'h40;
        step();
        quiet();
        checks++;
        if ({c_addr, p_taken, p_target, inst_pc} !==
            {32'h40, 1'b1, 32'h40, 32'h10} ||
            dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL pred_taken got %h/%b/%h/%h exp 40/1/40/10",
                     c_addr, p_taken, p_target, inst_pc);
        end
    endtask

    task automatic test_cache_miss();
        logic        v0;
        logic [31:0] i0;
        goto_pc(32'h20);
        v0 = valid;
        i0 = inst;
        c_stall = 1;
        for (int k = 0; k < 5; k++) begin
            c_data = $urandom;
            step();
            checks++;
            if ({c_addr, valid, inst} !== {32'h20, v0, i0} ||
                dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL miss_hold k=%0d got %h/%b/%h exp 20/%b/%h",
                         k, c_addr, valid, inst, v0, i0);
            end
        end
        c_stall = 0;
        c_data  = 32'hCAFE_0001;
        step();
        checks++;
        if ({valid, inst, inst_pc, c_addr} !==
            {1'b1, 32'hCAFE_0001, 32'h20, 32'h24}) begin
            errors++;
            $display("FAIL miss_accept got %b/%h/%h/%h",
                     valid, inst, inst_pc, c_addr);
        end
    endtask

    task automatic test_redirect_hit();
        goto_pc(32'h30);
        redir    = 1;
        redir_pc = 32'h103;
        step();
        quiet();
        checks++;
        if ({c_addr, valid, inst} !== {32'h100, 1'b0, NOP}) begin
            errors++;
            $display("FAIL redir_hit got %h/%b/%h exp 100/0/%h",
                     c_addr, valid, inst, NOP);
        end
        step();
        checks++;
        if ({valid, inst_pc} !== {1'b1, 32'h100} ||
            dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL redir_hit_next got %b/%h exp 1/100",
                     valid, inst_pc);
        end
    endtask

    task automatic test_redirect_miss();
        goto_pc(32'h50);
        step();
        goto_pc(32'h50);
        c_stall  = 1;
        redir    = 1;
        redir_pc = 32'h200;
        c_data   = 32'hBAD0_0050;
        step();
        redir = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({c_addr, valid} !== {32'h50, 1'b0}) begin
                errors++;
                $display("FAIL flush_hold k=%0d got %h/%b exp 50/0",
                         k, c_addr, valid);
            end
            step();
        end
        c_stall = 0;
        step();
        checks++;
        if ({c_addr, valid, inst} !== {32'h200, 1'b0, NOP}) begin
            errors++;
            $display("FAIL flush_done got %h/%b/%h exp 200/0/%h",
                     c_addr, valid, inst, NOP);
        end
        c_data = 32'h1111_2222;
        step();
        checks++;
        if ({valid, inst_pc, inst} !== {1'b1, 32'h200, 32'h1111_2222} ||
            dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL flush_next got %b/%h/%h exp 1/200/11112222",
                     valid, inst_pc, inst);
        end
    endtask

    task automatic test_youngest_wins();
        goto_pc(32'h60);
        c_stall  = 1;
        redir    = 1;
        redir_pc = 32'h300;
        step();
        redir_pc = 32'h400;
        step();
        redir   = 0;
        c_stall = 0;
        step();
        checks++;
        if (c_addr !== 32'h400 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL youngest got %h exp 400", c_addr);
        end
    endtask

    task automatic test_stall_wrap();
        logic [162:0] snap;
        goto_pc(32'hFFFF_FFFC);
        snap  = dut_vec();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            c_data = $urandom;
            step();
            checks++;
            if (dut_vec() !== snap || c_addr !== 32'hFFFF_FFFC) begin
                errors++;
                $display("FAIL stall_hold k=%0d got %h exp %h",
                         k, dut_vec(), snap);
            end
        end
        stall = 0;
        step();
        checks++;
        if ({c_addr, inst_pc, p_target} !==
            {32'h0, 32'hFFFF_FFFC, 32'h0} ||
            dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL wrap got %h/%h/%h exp 0/fffffffc/0",
                     c_addr, inst_pc, p_target);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            stall    = ($urandom_range(0, 99) < 20);
            redir    = ($urandom_range(0, 99) < 10);
            redir_pc = $urandom;
            bp_hit   = ($urandom_range(0, 99) < 30);
            bp_tgt   = $urandom;
            c_stall  = ($urandom_range(0, 99) < 30);
            c_data   = $urandom;
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random n=%0d got %h exp %h",
                             n, dut_vec(), mdl_vec());
            end
            if ($urandom_range(0, 199) == 0) begin
                rst = 0;
                #1;
                mdl_reset();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL async_rst got %h exp %h",
                             dut_vec(), mdl_vec());
                end
                step();
                rst = 1;
            end
        end
        quiet();
    endtask

    initial begin
        rst = 0;
        quiet();
        mdl_reset();
        test_reset();
        test_reset_release();
        test_idle_redirect();
        test_pred_taken();
        test_cache_miss();
        test_redirect_hit();
        test_redirect_miss();
        test_youngest_wins();
        test_stall_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
